acc_cpu_mc: RTL

Parametrised multicycle accumulator CPU. It is the next generation of the team's fetch/execute accumulator core and adds:
- configurable data and address widths;
- a stall-capable memory handshake, so it can sit behind wait-stated RAM or a bus arbiter;
- subtract, XOR, carry flag, conditional branches and HALT.

It connects to a single unified instruction/data memory port and exposes debug state for the testbench and top-level.

---
 rtl/acc_cpu_pkg.sv | 41 ++++
 rtl/acc_cpu_alu.sv | 73 +++++++
 rtl/acc_cpu_mc.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the multicycle accumulator core.
// Contents: opcode enumeration, FSM state enumeration and the is_mem_op helper.
package acc_cpu_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ADD  = 4'h1,
      OP_SHL  = 4'h2,
      OP_SHR  = 4'h3,
      OP_LDI  = 4'h4,
      OP_LD   = 4'h5,
      OP_OR   = 4'h6,
      OP_ST   = 4'h7,
      OP_BR   = 4'h8,
      OP_AND  = 4'h9,
      OP_SUB  = 4'hA,
      OP_BZ   = 4'hB,
      OP_BN   = 4'hC,
      OP_XOR  = 4'hD,
      OP_BC   = 4'hE,
      OP_HALT = 4'hF
   } opcode_e;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_HALT  = 2'd2
   } state_e;

   // True for opcodes whose EXEC phase performs a memory access.
   function automatic logic is_mem_op(input opcode_e op);
      logic res;
      case (op)
         OP_ADD, OP_SHL, OP_SHR, OP_LD, OP_OR,
         OP_ST, OP_AND, OP_SUB, OP_XOR: res = 1'b1;
         default:                       res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Combinational ALU of the accumulator core.
// Ports:
//   op_i          opcode of the executing instruction
//   ac_i          current accumulator
//   m_i           operand value (memory word, or zero-extended immediate for LDI)
//   c_i           current carry flag
//   result_o      new accumulator value (valid when writes_ac_o)
//   carry_next_o  new carry flag (equals c_i except for ADD/SUB)
//   writes_ac_o   the opcode updates the accumulator
module acc_cpu_alu
   import acc_cpu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  opcode_e               op_i,
   input  logic [DATA_WIDTH-1:0] ac_i,
   input  logic [DATA_WIDTH-1:0] m_i,
   input  logic                  c_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  carry_next_o,
   output logic                  writes_ac_o
);

   // Result, carry and write-enable selection per opcode.
   always_comb begin
      result_o     = ac_i;
      carry_next_o = c_i;
      writes_ac_o  = 1'b0;
      case (op_i)
         OP_ADD: begin
            {carry_next_o, result_o} = {1'b0, ac_i} + {1'b0, m_i};
            writes_ac_o              = 1'b1;
         end
         // The shift amount is the whole operand; amounts >= width give zero.
         OP_SHL: begin
            result_o    = ac_i << m_i;
            writes_ac_o = 1'b1;
         end
         OP_SHR: begin
            result_o    = ac_i >> m_i;
            writes_ac_o = 1'b1;
         end
         OP_LDI, OP_LD: begin
            result_o    = m_i;
            writes_ac_o = 1'b1;
         end
         OP_OR: begin
            result_o    = ac_i | m_i;
            writes_ac_o = 1'b1;
         end
         OP_AND: begin
            result_o    = ac_i & m_i;
            writes_ac_o = 1'b1;
         end
         OP_XOR: begin
            result_o    = ac_i ^ m_i;
            writes_ac_o = 1'b1;
         end
         // Carry holds the borrow: set when AC < M (unsigned).
         OP_SUB: begin
            result_o     = ac_i - m_i;
            carry_next_o = (ac_i < m_i);
            writes_ac_o  = 1'b1;
         end
         default: begin
            result_o     = ac_i;
            carry_next_o = c_i;
            writes_ac_o  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/acc_cpu_mc.sv
// Multicycle accumulator CPU with a single stall-capable memory port.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   mem_req/addr/we/wdata memory request; held stable until mem_ready is seen
//   mem_ready, mem_rdata  access completes on an edge with mem_req & mem_ready
//   halted                core executed HALT (cleared only by reset)
//   pc_dbg/ac_dbg/carry_dbg architectural state for observation
module acc_cpu_mc
   import acc_cpu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = {ADDR_WIDTH{1'b0}}
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_ready,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  halted,
   output logic [ADDR_WIDTH-1:0] pc_dbg,
   output logic [DATA_WIDTH-1:0] ac_dbg,
   output logic                  carry_dbg
);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [DATA_WIDTH-1:0]   ir_q, ir_d;
   logic [DATA_WIDTH-1:0]   ac_q, ac_d;
   logic                    c_q, c_d;

   opcode_e                 opcode_s;
   logic [ADDR_WIDTH-1:0]   operand_s;
   logic                    mem_op_s;
   logic [DATA_WIDTH-1:0]   alu_m_s;
   logic [DATA_WIDTH-1:0]   alu_result_s;
   logic                    alu_carry_s;
   logic                    alu_writes_s;
   logic                    unused_ir_bits_s;

   assign opcode_s         = opcode_e'(ir_q[DATA_WIDTH-1 -: 4]);
   assign operand_s        = ir_q[ADDR_WIDTH-1:0];
   assign mem_op_s         = is_mem_op(opcode_s);
   // Bits between the opcode and the operand carry no meaning.
   assign unused_ir_bits_s = ^ir_q[DATA_WIDTH-5:ADDR_WIDTH];

   // LDI feeds the zero-extended immediate through the ALU's M input.
   assign alu_m_s = mem_op_s ? mem_rdata
                             : {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, operand_s};

   acc_cpu_alu #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_alu (
      .op_i         (opcode_s),
      .ac_i         (ac_q),
      .m_i          (alu_m_s),
      .c_i          (c_q),
      .result_o     (alu_result_s),
      .carry_next_o (alu_carry_s),
      .writes_ac_o  (alu_writes_s)
   );

   // Memory port muxing; reset suppresses the request in the same cycle.
   always_comb begin
      mem_req  = 1'b0;
      mem_addr = pc_q;
      mem_we   = 1'b0;
      if (reset) begin
         mem_req = 1'b0;
      end else begin
         case (state_q)
            S_FETCH: begin
               mem_req  = 1'b1;
               mem_addr = pc_q;
            end
            S_EXEC: begin
               if (mem_op_s) begin
                  mem_req  = 1'b1;
                  mem_addr = operand_s;
                  mem_we   = (opcode_s == OP_ST);
               end else begin
                  mem_req  = 1'b0;
               end
            end
            default: begin
               mem_req = 1'b0;
            end
         endcase
      end
   end

   assign mem_wdata = ac_q;
   assign halted    = (state_q == S_HALT) && !reset;
   assign pc_dbg    = pc_q;
   assign ac_dbg    = ac_q;
   assign carry_dbg = c_q;

   // Next-state logic for the FETCH/EXEC/HALT sequencer and architectural state.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      ac_d    = ac_q;
      c_d     = c_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               ir_d    = mem_rdata;
               pc_d    = pc_q + ADDR_WIDTH'(1'b1);
               state_d = S_EXEC;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_EXEC: begin
            if (mem_op_s) begin
               // Stores leave AC alone: the ALU reports no AC write for ST.
               if (mem_ready) begin
                  ac_d    = alu_writes_s ? alu_result_s : ac_q;
                  c_d     = alu_carry_s;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_EXEC;
               end
            end else begin
               ac_d    = alu_writes_s ? alu_result_s : ac_q;
               c_d     = alu_carry_s;
               state_d = S_FETCH;
               // Taken branches overwrite the PC+1 from the fetch.
               case (opcode_s)
                  OP_BR:   pc_d = operand_s;
                  OP_BZ:   pc_d = (ac_q == {DATA_WIDTH{1'b0}}) ? operand_s : pc_q;
                  OP_BN:   pc_d = ac_q[DATA_WIDTH-1] ? operand_s : pc_q;
                  OP_BC:   pc_d = c_q ? operand_s : pc_q;
                  OP_HALT: state_d = S_HALT;
                  default: pc_d = pc_q;
               endcase
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= {DATA_WIDTH{1'b0}};
         ac_q    <= {DATA_WIDTH{1'b0}};
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ac_q    <= ac_d;
         c_q     <= c_d;
      end
   end

endmodule
